cat_sprite_fetch: RTL
=====================

// Module: cat_sprite_fetch
// PURPOSE
//  Per-pixel sprite fetch stage directly upstream of the cat palette lookup.
//  - Takes the VGA draw coordinate, decides whether it falls inside the cat sprite box, and reads the 4-bit colour index from sprite ROM.
//  - Emits index + valid, aligned by a fixed 2-cycle pipeline, for the palette and the colour mapper.
//  - Owns the sprite's animation frame counter.
//  - Latches sprite position and flip once per video frame so the sprite never tears mid-frame.
// PARAMETERS
//  SPR_W        32   sprite width in pixels (power of two)
//  SPR_H        32   sprite height in pixels (power of two)
//  NUM_FRAMES   4    animation frames stored back-to-back in ROM
//  FRAME_HOLD   8    frame_tick pulses each animation frame is shown
//  TRANSP_IDX   4'h0 palette index treated as transparent
// PORTS
//  Clk            in   1   system clock
//  Reset_n        in   1   asynchronous reset, active low
//  frame_tick     in   1   1-cycle pulse at start of vertical blank
//  DrawX          in   10  current pixel column, 0..639
//  DrawY          in   10  current pixel row, 0..479
//  pix_en         in   1   pixel strobe; pipeline advances only when high
//  pos_x          in   10  requested sprite top-left X
//  pos_y          in   10  requested sprite top-left Y
//  flip_h         in   1   requested horizontal mirror
//  anim_en        in   1   animation enable
//  index          out  4   palette index for the pixel, to cat palette
//  pix_valid      out  1   pixel inside box and index != TRANSP_IDX
//  anim_frame     out  $clog2(NUM_FRAMES)  current animation frame
// BEHAVIOUR
//  Reset (async, Reset_n=0):
//  - Every flop cleared.
//  - index=0, pix_valid=0, anim_frame=0; latched pos/flip=0; hold counter=0.
//  - Takes effect immediately, including mid-line or mid-pipeline.
//  Frame latch:
//  - On Clk edge with frame_tick=1, latch pos_x, pos_y, flip_h.
//  - Pixels on that same edge use the OLD latched values; new values apply from the next cycle.
//  Animation:
//  - On frame_tick with anim_en=1, hold_cnt++.
//  - When hold_cnt==FRAME_HOLD-1: hold_cnt<=0, anim_frame<=anim_frame+1, wrapping NUM_FRAMES-1 -> 0.
//  - anim_en=0: hold_cnt and anim_frame hold their values (no clear).
//  - anim_frame changes take effect for pixels from the next cycle, as for the frame latch.
//  Stage 0 (combinational, then registered on pix_en):
//  - Compare in 11-bit unsigned so pos+W never wraps.
//  - in_box = DrawX>=lx && DrawX<lx+SPR_W && DrawY>=ly && DrawY<ly+SPR_H.
//  - rx = DrawX-lx; ry = DrawY-ly; cx = flip ? SPR_W-1-rx : rx.
//  - addr = anim_frame*SPR_W*SPR_H + ry*SPR_W + cx. Shifts/concat only; no multipliers.
//  - Out-of-box: addr forced to 0; in_box flag still carried.
//  Stage 1: synchronous ROM read, 1-cycle latency; in_box delayed alongside the ROM read.
//  Stage 2:
//  - index <= in_box_d ? rom_q : TRANSP_IDX.
//  - pix_valid <= in_box_d && rom_q != TRANSP_IDX.
//  Timing:
//  - Latency is exactly 2 pix_en strobes from DrawX/DrawY sample to index/pix_valid.
//  - pix_en=0 stalls all stages; outputs hold.
//  - Sprite partly off-screen (lx>640-SPR_W): only on-screen columns are valid; no wrap to column 0.
// STRUCTURE
//  - cat_pkg holds SPR_W, SPR_H, NUM_FRAMES, ROM_DEPTH=SPR_W*SPR_H*NUM_FRAMES, typedef logic [3:0] pal_idx_t, TRANSP_IDX.
//  - Sub-module cat_sprite_rom: sync-read ROM (addr in, pal_idx_t out, 1 cycle), initialised from the sprite .mem file.
//  - This block holds the frame latch, animation counter and 3-stage pipeline.
// TESTING
//  1. Reset_n=0 mid-stream with pix_valid=1 -> index=0, pix_valid=0, anim_frame=0 without waiting for a Clk edge.
//  2. pos=(100,50), frame_tick, flip=0; DrawX=100, DrawY=50 -> 2 strobes later index=ROM[0]; DrawX=131 -> ROM[31]; DrawX=132 -> pix_valid=0.
//  3. flip_h=1, pos=(100,50): DrawX=100, DrawY=51 -> index=ROM[32+31]=ROM[63].
//  4. anim_en=1, 8 frame_ticks -> anim_frame 0->1; after 32 ticks wraps to 0; anim_en=0 with 5 ticks -> no change.
//  5. pos_x changes to 200 without frame_tick -> box still at 100; after frame_tick, same-edge pixel uses 100, next cycle uses 200.
//  6. pix_en toggled 1,0,0,1 -> outputs hold during 0s; pos_x=620 -> DrawX 620..639 valid, DrawX=0..11 invalid.

Source files
------------

// File: rtl/cat_pkg.sv
// Shared sizing, types and sprite art for the cat sprite path.
// Latency: n/a (constants, types and a constant-evaluated helper only).
// Backpressure: n/a.
package cat_pkg;

    localparam int SPR_W      = 32;
    localparam int SPR_H      = 32;
    localparam int NUM_FRAMES = 4;
    localparam int FRAME_HOLD = 8;
    localparam int ROM_DEPTH  = SPR_W * SPR_H * NUM_FRAMES;

    localparam int COORD_W = 10;
    localparam int COL_W   = $clog2(SPR_W);
    localparam int ROW_W   = $clog2(SPR_H);
    localparam int FRM_W   = $clog2(NUM_FRAMES);
    localparam int HOLD_W  = $clog2(FRAME_HOLD);
    localparam int ADDR_W  = $clog2(ROM_DEPTH);

    typedef logic [3:0] pal_idx_t;

    localparam pal_idx_t TRANSP_IDX = 4'h0;

    // Sprite art, one palette index per ROM word. Frames are stored
    // back-to-back, rows of SPR_W pixels within a frame. The pattern is a
    // diagonal colour ramp that shifts per frame, so every word is
    // distinguishable and some words land on the transparent index.
    function automatic pal_idx_t sprite_pixel(input int unsigned a);
        int unsigned col;
        int unsigned row;
        int unsigned frm;
        col = a % SPR_W;
        row = (a / SPR_W) % SPR_H;
        frm = a / (SPR_W * SPR_H);
        return pal_idx_t'((col + 3 * row + 5 * frm + 1) % 16);
    endfunction

endpackage

// File: rtl/cat_sprite_rom.sv
// Synchronous-read sprite ROM holding all animation frames.
// Latency: 1 cycle from rd_addr to rd_dat when rd_en is high.
// Backpressure: rd_en low holds rd_dat; no other flow control.
//
// Ports:
//   clk, rst_n  clock and async active-low reset (clears the read register)
//   rd_en       advance strobe; read register only loads when high
//   rd_addr     word address {frame, row, col}
//   rd_dat      registered palette index
module cat_sprite_rom
    import cat_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output pal_idx_t          rd_dat
);

    // Constant table; each entry folds to a literal at elaboration.
    pal_idx_t rom_mem [ROM_DEPTH];

    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
        assign rom_mem[g] = sprite_pixel(g);
    end

    pal_idx_t rd_dat_d;
    pal_idx_t rd_dat_q;

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = rom_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/cat_sprite_fetch.sv
// Per-pixel cat sprite fetch: box test, ROM address, palette index + valid.
// Latency: exactly 2 pix_en strobes from DrawX/DrawY to index/pix_valid.
// Backpressure: pix_en low stalls every pipeline stage; outputs hold.
//
// Ports:
//   Clk, Reset_n         clock, async active-low reset (clears every flop)
//   frame_tick           start-of-vblank pulse: latches pos/flip, steps animation
//   DrawX, DrawY         current draw coordinate
//   pix_en               pixel strobe
//   pos_x, pos_y, flip_h requested sprite placement, sampled on frame_tick
//   anim_en              animation enable
//   index, pix_valid     palette index and "opaque sprite pixel" flag
//   anim_frame           current animation frame
module cat_sprite_fetch
    import cat_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               pix_en,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               flip_h,
    input  logic               anim_en,
    output pal_idx_t           index,
    output logic               pix_valid,
    output logic [FRM_W-1:0]   anim_frame
);

    // ------------------------------------------------------------------
    // Frame latch and animation state
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] lx_d, lx_q;
    logic [COORD_W-1:0] ly_d, ly_q;
    logic               flip_d, flip_q;
    logic [HOLD_W-1:0]  hold_d, hold_q;
    logic [FRM_W-1:0]   frame_d, frame_q;

    // Everything here samples on the frame_tick edge itself, so pixels on
    // that edge still see the previous values.
    always_comb begin
        lx_d    = lx_q;
        ly_d    = ly_q;
        flip_d  = flip_q;
        hold_d  = hold_q;
        frame_d = frame_q;
        if (frame_tick) begin
            lx_d   = pos_x;
            ly_d   = pos_y;
            flip_d = flip_h;
            if (anim_en) begin
                if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
                    hold_d  = '0;
                    frame_d = (frame_q == FRM_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lx_q    <= '0;
            ly_q    <= '0;
            flip_q  <= 1'b0;
            hold_q  <= '0;
            frame_q <= '0;
        end else begin
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            flip_q  <= flip_d;
            hold_q  <= hold_d;
            frame_q <= frame_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: box test and ROM address (combinational)
    // ------------------------------------------------------------------
    // One extra bit so lx + SPR_W near the right edge cannot wrap back
    // onto column 0.
    logic [COORD_W:0]  dx_ext, dy_ext, lx_ext, ly_ext;
    logic              s0_in_box;
    logic [COL_W-1:0]  s0_col;
    logic [COL_W-1:0]  s0_cx;
    logic [ROW_W-1:0]  s0_row;
    logic [ADDR_W-1:0] s0_addr;

    always_comb begin
        dx_ext = {1'b0, DrawX};
        dy_ext = {1'b0, DrawY};
        lx_ext = {1'b0, lx_q};
        ly_ext = {1'b0, ly_q};

        s0_in_box = (dx_ext >= lx_ext) && (dx_ext < lx_ext + (COORD_W + 1)'(SPR_W)) &&
                    (dy_ext >= ly_ext) && (dy_ext < ly_ext + (COORD_W + 1)'(SPR_H));

        // Only the low bits of the offsets matter inside the box.
        s0_col = DrawX[COL_W-1:0] - lx_q[COL_W-1:0];
        s0_row = DrawY[ROW_W-1:0] - ly_q[ROW_W-1:0];

        // SPR_W is a power of two, so SPR_W-1-col is a bitwise invert.
        s0_cx = flip_q ? ~s0_col : s0_col;

        // Power-of-two geometry turns frame*W*H + row*W + col into a concat.
        s0_addr = s0_in_box ? {frame_q, s0_row, s0_cx} : '0;
    end

    // ------------------------------------------------------------------
    // Stage 1: ROM read, box flag travels alongside
    // ------------------------------------------------------------------
    pal_idx_t rom_dat;
    logic     s1_in_box_d, s1_in_box_q;

    cat_sprite_rom u_rom (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .rd_en   (pix_en),
        .rd_addr (s0_addr),
        .rd_dat  (rom_dat)
    );

    always_comb begin
        s1_in_box_d = s1_in_box_q;
        if (pix_en) begin
            s1_in_box_d = s0_in_box;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output register
    // ------------------------------------------------------------------
    pal_idx_t index_d, index_q;
    logic     pix_valid_d, pix_valid_q;

    always_comb begin
        index_d     = index_q;
        pix_valid_d = pix_valid_q;
        if (pix_en) begin
            index_d     = s1_in_box_q ? rom_dat : TRANSP_IDX;
            pix_valid_d = s1_in_box_q && (rom_dat != TRANSP_IDX);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_in_box_q <= 1'b0;
            index_q     <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            s1_in_box_q <= s1_in_box_d;
            index_q     <= index_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign index      = index_q;
    assign pix_valid  = pix_valid_q;
    assign anim_frame = frame_q;

endmodule
